// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the axil_reg_slave register block.
// Widths follow the register block's parameters; only 32-bit data is meaningful.
interface axil_reg_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file: NUM_REGS word registers with byte-strobed writes,
// independent read/write channels, and a flat copy of all registers for fabric logic.
module axil_reg_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] RESET_VALUE        = 32'h0
) (
    input  logic                                   clock,
    input  logic                                   reset,
    axil_reg_slave_if.slave                        s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);

    localparam int             DW          = C_S_AXI_DATA_WIDTH;
    localparam int             SW          = DW / 8;
    localparam int             IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] NUM_REGS_W  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [IDX_W-1:0] awidx_q, awidx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [DW-1:0]    regs_q [NUM_REGS];
    logic [DW-1:0]    regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic             commit;
    logic             wr_in_range, rd_in_range;
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    rd_word;
    logic             unused_ok;

    // Byte offsets and protection bits carry no meaning for a word register file.
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign s_axi.S_AXI_AWREADY = !reset && !aw_held_q && !bvalid_q;
    assign s_axi.S_AXI_WREADY  = !reset && !w_held_q && !bvalid_q;
    assign s_axi.S_AXI_ARREADY = !reset && !rvalid_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign b_hs   = bvalid_q && s_axi.S_AXI_BREADY;
    assign r_hs   = rvalid_q && s_axi.S_AXI_RREADY;
    assign commit = aw_held_q && w_held_q && !bvalid_q;

    assign ar_idx      = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_in_range = ({1'b0, awidx_q} < NUM_REGS_W);
    assign rd_in_range = ({1'b0, ar_idx} < NUM_REGS_W);

    always_comb begin
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else if (commit) begin
            aw_held_d = 1'b0;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end else if (commit) begin
            w_held_d = 1'b0;
        end
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit && wr_in_range) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < SW; b++) begin
                    if (awidx_q == IDX_W'(k) && wstrb_q[b]) begin
                        regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Reads sample the current flops, so a same-edge write commit is not yet visible.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? rd_word : '0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    // Holding registers are qualified by the held flags, so they need no reset.
    always_ff @(posedge clock) begin
        awidx_q <= awidx_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[k*DW +: DW] = regs_q[k];
    end

endmodule
